// File: rtl/decode_pipe.sv
// Buffered Hack-style instruction decoder: DEPTH-entry FIFO feeding a registered decode stage.
// Latency 2 edges from push to out_valid; in_ready depends only on occupancy, and outputs hold while out_valid & !out_ready.
module decode_pipe #(
  parameter int W      = 16,
  parameter int DEPTH  = 4,
  parameter int STRICT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_instr,
  output logic                         loadRegA,
  output logic                         loadRegD,
  output logic                         writeM,
  output logic                         selA,
  output logic                         selM,
  output logic                         memread,
  output logic [5:0]                   alu_ctl,
  output logic [2:0]                   jmp,
  output logic                         illegal,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [7:0]                   illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [W-1:0]  head;

  assign in_ready = (fifo_count < FULL);
  assign push     = in_valid & in_ready;
  assign pop      = (fifo_count != '0) & (~out_valid | out_ready);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_instr;
    end
  end

  // Power-of-two DEPTH lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  function automatic logic legal_comp(input logic a, input logic [5:0] c);
    case ({a, c})
      7'b0_101010, 7'b0_111111, 7'b0_111010, 7'b0_001100, 7'b0_110000,
      7'b0_001101, 7'b0_110001, 7'b0_001111, 7'b0_110011, 7'b0_011111,
      7'b0_110111, 7'b0_001110, 7'b0_110010, 7'b0_000010, 7'b0_010011,
      7'b0_000111, 7'b0_000000, 7'b0_010101,
      7'b1_110000, 7'b1_110001, 7'b1_110011, 7'b1_110111, 7'b1_110010,
      7'b1_000010, 7'b1_010011, 7'b1_000111, 7'b1_000000, 7'b1_010101:
        legal_comp = 1'b1;
      default: legal_comp = 1'b0;
    endcase
  endfunction

  logic       d_lra, d_lrd, d_wm, d_sela, d_selm, d_mrd, d_ill, c_legal;
  logic [5:0] d_alu;
  logic [2:0] d_jmp;

  always_comb begin
    d_lra   = 1'b0;
    d_lrd   = 1'b0;
    d_wm    = 1'b0;
    d_sela  = 1'b0;
    d_selm  = 1'b0;
    d_mrd   = 1'b0;
    d_ill   = 1'b0;
    d_alu   = '0;
    d_jmp   = '0;
    c_legal = legal_comp(head[12], head[11:6]) &
              ((head[14:13] == 2'b11) | (STRICT == 0));
    if (!head[15]) begin
      d_lra = 1'b1;
    end else begin
      d_sela = 1'b1;
      d_mrd  = head[12];
      d_selm = head[12];
      if (c_legal) begin
        d_lra = head[5];
        d_lrd = head[4];
        d_wm  = head[3];
        d_alu = head[11:6];
        d_jmp = head[2:0];
      end else begin
        d_ill = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      loadRegA  <= 1'b0;
      loadRegD  <= 1'b0;
      writeM    <= 1'b0;
      selA      <= 1'b0;
      selM      <= 1'b0;
      memread   <= 1'b0;
      alu_ctl   <= '0;
      jmp       <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_instr <= head;
      loadRegA  <= d_lra;
      loadRegD  <= d_lrd;
      writeM    <= d_wm;
      selA      <= d_sela;
      selM      <= d_selm;
      memread   <= d_mrd;
      alu_ctl   <= d_alu;
      jmp       <= d_jmp;
      illegal   <= d_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A word handshaken on a flush edge was still delivered, so it is counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (out_valid && out_ready && illegal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe (W=16, DEPTH=4, STRICT=1) with hand-computed expectations.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic        loadRegA, loadRegD, writeM, selA, selM, memread;
  logic [5:0]  alu_ctl;
  logic [2:0]  jmp;
  logic        illegal;
  logic [2:0]  fifo_count;
  logic [7:0]  illegal_cnt;

  int checks = 0;
  int failures = 0;

  decode_pipe #(.W(16), .DEPTH(4), .STRICT(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .loadRegA(loadRegA), .loadRegD(loadRegD), .writeM(writeM),
    .selA(selA), .selM(selM), .memread(memread),
    .alu_ctl(alu_ctl), .jmp(jmp), .illegal(illegal),
    .fifo_count(fifo_count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one word into an empty pipe with out_ready=1; returns with the word on the outputs.
  task automatic send_one(input logic [15:0] w);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = w;
    step();
    in_valid = 1'b0;
    chk("lat_edge1_vld", out_valid, 0);
    step();
    chk("lat_edge2_vld", out_valid, 1);
    chk("lat_instr", out_instr, w);
  endtask

  // Stall the output and offer n consecutive words starting at base.
  task automatic fill(input logic [15:0] base, input int n);
    int k;
    k = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 20 && k < n; c++) begin
      in_instr = base + 16'(k);
      @(posedge clk);
      if (in_ready) k++;
      #1;
    end
    in_valid = 1'b0;
    chk("fill_accepted", k, n);
  endtask

  initial begin
    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_icnt", illegal_cnt, 0);
    chk("rst_instr", out_instr, 0);
    reset = 1'b0;
    step();
    chk("rst_rdy", in_ready, 1);

    // A-instruction @7
    send_one(16'h0007);
    chk("a_lra", loadRegA, 1);
    chk("a_ctl", {loadRegD, writeM, selA, selM, memread, illegal}, 0);
    chk("a_alu", alu_ctl, 0);
    chk("a_jmp", jmp, 0);
    step();
    chk("a_drain", out_valid, 0);

    // D=M
    send_one(16'hFC10);
    chk("dm_ctl", {memread, selM, loadRegD, selA, loadRegA, writeM, illegal}, 7'b1111000);
    chk("dm_alu", alu_ctl, 6'b110000);
    chk("dm_jmp", jmp, 0);
    step();

    // 0;JMP
    send_one(16'hEA87);
    chk("jmp_jmp", jmp, 3'b111);
    chk("jmp_alu", alu_ctl, 6'b101010);
    chk("jmp_ill", illegal, 0);
    step();

    // M=D
    send_one(16'hE308);
    chk("md_ctl", {writeM, loadRegA, loadRegD, memread, selA}, 5'b10001);
    chk("md_alu", alu_ctl, 6'b001100);
    step();

    // a=1 with comp 111010 is not a legal M-form
    send_one(16'hFE90);
    chk("ill_flag", illegal, 1);
    chk("ill_lrd", loadRegD, 0);
    chk("ill_alu", alu_ctl, 0);
    chk("ill_sela", selA, 1);
    chk("ill_cnt_pre", illegal_cnt, 0);
    step();
    chk("ill_cnt_post", illegal_cnt, 1);

    // STRICT: I[14:13] != 11
    send_one(16'h8C10);
    chk("strict_ill", illegal, 1);
    chk("strict_alu", alu_ctl, 0);
    step();
    chk("strict_cnt", illegal_cnt, 2);

    // Backpressure: 5 words, 1 in output reg + 4 buffered
    fill(16'h0001, 5);
    chk("bp_cnt", fifo_count, 4);
    chk("bp_rdy", in_ready, 0);
    chk("bp_instr", out_instr, 16'h0001);
    in_valid = 1'b1;
    in_instr = 16'h0099;
    step();
    step();
    in_valid = 1'b0;
    chk("bp_hold_instr", out_instr, 16'h0001);
    chk("bp_hold_vld", out_valid, 1);
    chk("bp_hold_cnt", fifo_count, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_vld", out_valid, 1);
      chk("bp_drain_instr", out_instr, 32'(i + 1));
      step();
    end
    chk("bp_empty_vld", out_valid, 0);
    chk("bp_empty_cnt", fifo_count, 0);

    // Flush a full pipe while pushing
    fill(16'h0010, 5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 16'h0BAD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_vld", out_valid, 0);
    chk("fl_cnt", fifo_count, 0);
    chk("fl_icnt", illegal_cnt, 2);
    out_ready = 1'b1;
    step();
    step();
    chk("fl_absent", out_valid, 0);
    send_one(16'h0020);
    step();

    // Saturation: 300 illegal words streamed back to back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 16'h8C10;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("sat_icnt", illegal_cnt, 255);

    // Async reset between edges with 3 words buffered
    fill(16'h0040, 4);
    chk("ar_pre_cnt", fifo_count, 3);
    #3 reset = 1'b1;
    #1;
    chk("ar_cnt", fifo_count, 0);
    chk("ar_vld", out_valid, 0);
    chk("ar_instr", out_instr, 0);
    chk("ar_icnt", illegal_cnt, 0);
    #1 reset = 1'b0;
    step();
    chk("ar_rdy", in_ready, 1);
    send_one(16'h0033);
    step();
    chk("ar_post_drain", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter W, default 16: instruction width; W SHALL be >= 16, bits [W-1:16] ignored by decode, carried in out_instr.
REQ-002 Parameter DEPTH, default 4: input FIFO entries; power of two, >= 2.
REQ-003 Parameter STRICT, default 1: 1 = C-instruction requires I[14:13]=2'b11 and a legal comp code; 0 = comp legality check only.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 flush  in  1  synchronous pipeline discard (taken branch).
REQ-007 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-008 in_instr  in  W  instruction word.
REQ-009 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-010 out_instr  out  W  instruction that produced the current outputs.
REQ-011 loadRegA, loadRegD, writeM, selA, selM, memread  out  1 each  decoded controls.
REQ-012 alu_ctl  out  6  {zx,nx,zy,ny,f,no} = I[11:6] for legal C-instructions, else 0.
REQ-013 jmp  out  3  I[2:0] for legal C-instructions, else 0.
REQ-014 illegal  out  1  current output word failed the legality check.
REQ-015 fifo_count  out  $clog2(DEPTH+1)  FIFO occupancy.
REQ-016 illegal_cnt  out  8  saturating count of illegal words delivered.

Function
REQ-017 Push: in_valid & in_ready at an edge writes in_instr to the FIFO tail; in_ready = (fifo_count < DEPTH), registered-state only, no combinational path from out_ready.
REQ-018 Output register loads the FIFO head when FIFO non-empty and (!out_valid | out_ready); otherwise holds all outputs stable.
REQ-019 out_valid clears on out_ready with FIFO empty; outputs SHALL not change while out_valid & !out_ready.
REQ-020 Latency: word pushed at edge N into an empty pipe SHALL be presented with out_valid=1 after edge N+1; sustained throughput one word/cycle.
REQ-021 Push and pop in the same cycle SHALL leave fifo_count unchanged; full FIFO blocks push even if a pop occurs that cycle.
REQ-022 A-instruction (I[15]=0): loadRegA=1, all other controls, alu_ctl, jmp=0, illegal=0.
REQ-023 C-instruction: selA=1; memread=I[12]; selM=I[12]; loadRegA=I[5]; loadRegD=I[4]; writeM=I[3].
REQ-024 Legal comp, a=0: 101010,111111,111010,001100,110000,001101,110001,001111,110011,011111,110111,001110,110010,000010,010011,000111,000000,010101.
REQ-025 Legal comp, a=1: 110000,110001,110011,110111,110010,000010,010011,000111,000000,010101.
REQ-026 Illegal C-instruction: illegal=1; loadRegA, loadRegD, writeM, jmp, alu_ctl forced 0; selA=1, out_instr carried.
REQ-027 illegal_cnt increments on each out_valid & out_ready with illegal=1; saturates at 255.
REQ-028 flush: at the edge, FIFO emptied, out_valid=0, any concurrent push dropped; flush dominates all other events; illegal_cnt unaffected.
REQ-029 Pointers wrap modulo DEPTH with no bubble.

Reset
REQ-030 reset SHALL immediately clear FIFO (fifo_count=0), out_valid=0, all decoded outputs, out_instr=0, illegal_cnt=0; in_ready=1 after reset deasserts.
REQ-031 reset asserted mid-transfer SHALL discard all buffered words; first post-reset output is the first word pushed after reset.

Verification
REQ-032 Push 0x0007 into empty pipe, out_ready=1 -> out_valid after 2 edges, loadRegA=1, alu_ctl=0, jmp=0.
REQ-033 Push 0xFC10 (D=M) -> memread=1, selM=1, loadRegD=1, alu_ctl=110000, illegal=0; push 0xEA87 (0;JMP) -> jmp=111, alu_ctl=101010.
REQ-034 Push 0xFE90 (a=1, comp 111010) -> illegal=1, loadRegD=0, illegal_cnt=1 after handshake; STRICT=1 push 0x8C10 -> illegal=1.
REQ-035 Hold out_ready=0, push 5 words with DEPTH=4 -> 1 in output reg, fifo_count=4, in_ready=0, outputs stable; release -> words in order, no loss/duplication.
REQ-036 Full pipe, assert flush with in_valid=1 -> next cycle out_valid=0, fifo_count=0; pushed word absent.
REQ-037 Async reset pulse between edges with fifo_count=3 -> fifo_count=0, out_valid=0 before next edge; 300 illegal words -> illegal_cnt=255.
